vx_csr_rmw: RTL and testbench
=============================

// Module: vx_csr_rmw
// PURPOSE
//  Issue stage directly upstream of the per-core CSR register file (VX_csr_data).
//  Accepts decoded CSR instructions, reads the addressed CSR, and computes the
//  read-modify-write value for CSRRW/CSRRS/CSRRC and their immediate forms.
//  Drives the CSR file's read and write ports, then returns the old CSR value to
//  writeback through a registered valid/ready response.
//  Stalls FP-CSR accesses while the FPU still has fflags updates in flight.
// PARAMETERS
//  CORE_ID      0  core index, forwarded into assertion messages only
// PORTS
//  clk               in   1                  clock
//  reset             in   1                  synchronous, active-high reset
//  req_valid         in   1                  request valid
//  req_ready         out  1                  request accepted when valid&ready
//  req_wid           in   `NW_BITS           warp id
//  req_tmask         in   `NUM_THREADS       thread mask, passed through
//  req_PC            in   32                 PC, passed through
//  req_rd            in   5                  destination register
//  req_wb            in   1                  writeback enable, passed through
//  req_op            in   2                  `CSR_RW / `CSR_RS / `CSR_RC
//  req_use_imm       in   1                  1: source = zext(req_imm); 0: source = req_rs1_data
//  req_imm           in   5                  uimm field
//  req_addr          in   `CSR_ADDR_BITS     CSR address
//  req_rs1_data      in   32                 rs1 value (thread 0 lane)
//  csr_read_enable   out  1                  to CSR file
//  csr_read_addr     out  `CSR_ADDR_BITS     to CSR file
//  csr_read_wid      out  `NW_BITS           to CSR file
//  csr_read_data     in   32                 combinational read data from CSR file
//  csr_write_enable  out  1                  to CSR file
//  csr_write_addr    out  `CSR_ADDR_BITS     to CSR file
//  csr_write_wid     out  `NW_BITS           to CSR file
//  csr_write_data    out  `CSR_WIDTH         to CSR file
//  fpu_pending       in   `NUM_WARPS         per-warp: FPU ops outstanding
//  rsp_valid         out  1                  response valid
//  rsp_ready         in   1                  writeback ready
//  rsp_wid/tmask/PC/rd/wb  out  as req       registered pass-through
//  rsp_data          out  32                 old CSR value
//  busy              out  1                  req_valid | rsp_valid
// BEHAVIOUR
//  - Reset: rsp_valid=0; all rsp_* payload=0; stall counter=0.
//    No csr_write_enable in the reset cycle.
//  - fp_hazard = req_addr in {FFLAGS,FRM,FCSR} & fpu_pending[req_wid].
//  - req_ready = ~reset & ~fp_hazard & (~rsp_valid | rsp_ready).
//    This is a single response register; full-throughput back-to-back operation
//    is allowed when rsp_ready=1.
//  - fire = req_valid & req_ready.
//    On fire, csr_read_* are driven the same cycle (read_enable = fire; addr/wid
//    come from req).
//  - src = req_use_imm ? 32'(req_imm) : req_rs1_data.
//  - new value: RW: src; RS: old|src; RC: old&~src.
//  - Write-needed rules:
//    RW: always.
//    RS/RC: only if src!=0 (covers rs1=x0 and uimm=0).
//    Read-only CSRs (req_addr[11:10]==2'b11) are never written.
//  - csr_write_enable = fire & write-needed. Write lands at the next edge.
//    A same-cycle read returns the pre-write value.
//    The next accepted request to the same CSR/warp reads the updated value;
//    no bypass is required.
//  - Response: on fire, rsp_data<=csr_read_data, payload<=req_* and rsp_valid<=1.
//    Latency is 1 cycle.
//  - rsp_valid&~rsp_ready: payload holds stable; req_ready=0.
//  - rsp_valid&rsp_ready&~fire: rsp_valid<=0.
//  - Reset mid-operation: the response is dropped (rsp_valid<=0); no write is issued.
//  - Invalid-address detection is the CSR file's assertion; this block does not filter.
// CONFIGURATION
//  - `CSR_STALL_CNT_EN defined:
//    Adds output perf_csr_stalls [43:0], counting cycles where req_valid&~req_ready.
//    The counter saturates at all-ones and resets to 0.
//  - `CSR_STALL_CNT_EN undefined: no port and no counter logic.
// STRUCTURE
//  - In VX_define.vh: `CSR_RW=2'd1, `CSR_RS=2'd2, `CSR_RC=2'd3.
//    Also `CSR_FFLAGS/FRM/FCSR and the read-only range test macro.
//  - Natural sub-module: VX_pipe_register for the response stage
//    (enable = fire | rsp_ready, reset clears valid).
// TESTING
//  1. CSRRW MSCRATCH-class CSR (MTVEC) old=0, rs1=32'h8000_0100
//     -> rsp_data=0, write_data=32'h8000_0100, rsp_valid 1 cycle after fire.
//  2. CSRRS MIE old=32'h8, rs1=x0 (0) -> no write_enable, rsp_data=32'h8.
//     CSRRSI uimm=5'h3 -> write_data=32'hB.
//  3. CSRRC with use_imm, FCSR old=8'hE1, imm=5'h01 -> write_data=8'hE0.
//     With fpu_pending[wid]=1 for 3 cycles -> req_ready=0 for those 3 cycles;
//     perf_csr_stalls=3 under `CSR_STALL_CNT_EN.
//  4. CSRRW CYCLE (read-only) -> write_enable stays 0; rsp_data=cycle[31:0].
//  5. Backpressure: rsp_ready=0 for 4 cycles with a second request pending
//     -> payload stable, second request accepted on the cycle rsp_ready=1,
//     no lost or duplicated response.
//  6. Assert reset while rsp_valid=1 -> rsp_valid=0 next cycle; no write is issued.

Source files
------------

// File: rtl/vx_csr_rmw_pkg.sv
// vx_csr_rmw_pkg: shared constants, op encodings, response bundle
// and small CSR helpers for the CSR read-modify-write issue stage.
package vx_csr_rmw_pkg;

    localparam int NUM_WARPS     = 4;
    localparam int NW_BITS       = 2;
    localparam int NUM_THREADS   = 4;
    localparam int CSR_ADDR_BITS = 12;
    localparam int CSR_WIDTH     = 32;

    localparam logic [1:0] CSR_RW = 2'd1;
    localparam logic [1:0] CSR_RS = 2'd2;
    localparam logic [1:0] CSR_RC = 2'd3;

    localparam logic [CSR_ADDR_BITS-1:0] CSR_FFLAGS = 12'h001;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FRM    = 12'h002;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FCSR   = 12'h003;

    typedef struct packed {
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            pc;
        logic [4:0]             rd;
        logic                   wb;
        logic [31:0]            data;
    } csr_rsp_t;

    function automatic logic is_fp_csr(input logic [CSR_ADDR_BITS-1:0] a);
        return (a == CSR_FFLAGS) || (a == CSR_FRM) || (a == CSR_FCSR);
    endfunction

    function automatic logic is_ro_csr(input logic [CSR_ADDR_BITS-1:0] a);
        return a[11:10] == 2'b11;
    endfunction

    function automatic logic [CSR_WIDTH-1:0] rmw_value(
        input logic [1:0]  op,
        input logic [31:0] old,
        input logic [31:0] src
    );
        logic [CSR_WIDTH-1:0] v;
        v = src;
        case (op)
            CSR_RS:  v = old | src;
            CSR_RC:  v = old & ~src;
            default: v = src;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vx_csr_rmw_pipe_reg.sv
// vx_csr_rmw_pipe_reg: single-entry valid+payload stage register.
// Ports: clk, reset (sync, high), i_enable, i_valid, i_data -> o_valid, o_data.
module vx_csr_rmw_pipe_reg #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic [DATAW-1:0] i_data,
    output logic             o_valid,
    output logic [DATAW-1:0] o_data
);

    logic             r_valid;
    logic [DATAW-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_enable) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/vx_csr_rmw.sv
// vx_csr_rmw: CSR issue stage. Reads the addressed CSR, computes and writes
// the RW/RS/RC result, and returns the old value through a registered response.
// Ports: req_* in (valid/ready), csr_read_*/csr_write_* to the CSR file,
// fpu_pending per warp, rsp_* out (valid/ready), busy.
// Option CSR_STALL_CNT_EN adds perf_csr_stalls[43:0] (saturating stall cycles).
module vx_csr_rmw
    import vx_csr_rmw_pkg::*;
#(
    parameter int CORE_ID = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [NW_BITS-1:0]       req_wid,
    input  logic [NUM_THREADS-1:0]   req_tmask,
    input  logic [31:0]              req_PC,
    input  logic [4:0]               req_rd,
    input  logic                     req_wb,
    input  logic [1:0]               req_op,
    input  logic                     req_use_imm,
    input  logic [4:0]               req_imm,
    input  logic [CSR_ADDR_BITS-1:0] req_addr,
    input  logic [31:0]              req_rs1_data,
    output logic                     csr_read_enable,
    output logic [CSR_ADDR_BITS-1:0] csr_read_addr,
    output logic [NW_BITS-1:0]       csr_read_wid,
    input  logic [31:0]              csr_read_data,
    output logic                     csr_write_enable,
    output logic [CSR_ADDR_BITS-1:0] csr_write_addr,
    output logic [NW_BITS-1:0]       csr_write_wid,
    output logic [CSR_WIDTH-1:0]     csr_write_data,
    input  logic [NUM_WARPS-1:0]     fpu_pending,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [NW_BITS-1:0]       rsp_wid,
    output logic [NUM_THREADS-1:0]   rsp_tmask,
    output logic [31:0]              rsp_PC,
    output logic [4:0]               rsp_rd,
    output logic                     rsp_wb,
    output logic [31:0]              rsp_data,
    output logic                     busy
`ifdef CSR_STALL_CNT_EN
    ,
    output logic [43:0]              perf_csr_stalls
`endif
);

    localparam int RSP_W = $bits(csr_rsp_t);

    logic        w_fp_hazard;
    logic        w_fire;
    logic        w_write_need;
    logic [31:0] w_src;
    csr_rsp_t    w_rsp_d;
    csr_rsp_t    w_rsp_q;

    // FP CSRs must not be touched while fflags updates are still in flight
    assign w_fp_hazard = is_fp_csr(req_addr) & fpu_pending[req_wid];
    assign req_ready   = ~reset & ~w_fp_hazard & (~rsp_valid | rsp_ready);
    assign w_fire      = req_valid & req_ready;

    assign w_src = req_use_imm ? {27'b0, req_imm} : req_rs1_data;

    // RS/RC with a zero source are pure reads
    always_comb begin
        w_write_need = 1'b0;
        case (req_op)
            CSR_RW:  w_write_need = 1'b1;
            CSR_RS,
            CSR_RC:  w_write_need = (w_src != 32'd0);
            default: w_write_need = 1'b0;
        endcase
        if (is_ro_csr(req_addr))
            w_write_need = 1'b0;
    end

    assign csr_read_enable  = w_fire;
    assign csr_read_addr    = req_addr;
    assign csr_read_wid     = req_wid;

    assign csr_write_enable = w_fire & w_write_need;
    assign csr_write_addr   = req_addr;
    assign csr_write_wid    = req_wid;
    assign csr_write_data   = rmw_value(req_op, csr_read_data, w_src);

    assign w_rsp_d.wid   = req_wid;
    assign w_rsp_d.tmask = req_tmask;
    assign w_rsp_d.pc    = req_PC;
    assign w_rsp_d.rd    = req_rd;
    assign w_rsp_d.wb    = req_wb;
    assign w_rsp_d.data  = csr_read_data;

    vx_csr_rmw_pipe_reg #(
        .DATAW (RSP_W)
    ) u_rsp_reg (
        .clk      (clk),
        .reset    (reset),
        .i_enable (w_fire | rsp_ready),
        .i_valid  (w_fire),
        .i_data   (w_rsp_d),
        .o_valid  (rsp_valid),
        .o_data   (w_rsp_q)
    );

    assign rsp_wid   = w_rsp_q.wid;
    assign rsp_tmask = w_rsp_q.tmask;
    assign rsp_PC    = w_rsp_q.pc;
    assign rsp_rd    = w_rsp_q.rd;
    assign rsp_wb    = w_rsp_q.wb;
    assign rsp_data  = w_rsp_q.data;

    assign busy = req_valid | rsp_valid;

`ifdef CSR_STALL_CNT_EN
    logic [43:0] r_stalls;

    always_ff @(posedge clk) begin
        if (reset)
            r_stalls <= '0;
        else if (req_valid && !req_ready && r_stalls != '1)
            r_stalls <= r_stalls + 44'd1;
    end

    assign perf_csr_stalls = r_stalls;
`endif

    always_ff @(posedge clk) begin
        if (!reset && rsp_valid && !rsp_ready)
            assert (!w_fire)
            else $error("vx_csr_rmw[%0d]: accept while response stalled", CORE_ID);
    end

endmodule

// File: tb/tb_vx_csr_rmw.sv
// tb_vx_csr_rmw: directed vectors against a behavioural CSR file,
// covering RW/RS/RC, FP hazard stall, read-only CSR, backpressure, reset.
module tb_vx_csr_rmw;
    import vx_csr_rmw_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     req_valid;
    logic                     req_ready;
    logic [NW_BITS-1:0]       req_wid;
    logic [NUM_THREADS-1:0]   req_tmask;
    logic [31:0]              req_PC;
    logic [4:0]               req_rd;
    logic                     req_wb;
    logic [1:0]               req_op;
    logic                     req_use_imm;
    logic [4:0]               req_imm;
    logic [CSR_ADDR_BITS-1:0] req_addr;
    logic [31:0]              req_rs1_data;
    logic                     csr_read_enable;
    logic [CSR_ADDR_BITS-1:0] csr_read_addr;
    logic [NW_BITS-1:0]       csr_read_wid;
    logic [31:0]              csr_read_data;
    logic                     csr_write_enable;
    logic [CSR_ADDR_BITS-1:0] csr_write_addr;
    logic [NW_BITS-1:0]       csr_write_wid;
    logic [CSR_WIDTH-1:0]     csr_write_data;
    logic [NUM_WARPS-1:0]     fpu_pending;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [NW_BITS-1:0]       rsp_wid;
    logic [NUM_THREADS-1:0]   rsp_tmask;
    logic [31:0]              rsp_PC;
    logic [4:0]               rsp_rd;
    logic                     rsp_wb;
    logic [31:0]              rsp_data;
    logic                     busy;
`ifdef CSR_STALL_CNT_EN
    logic [43:0]              perf;
`endif

    always #5 clk = ~clk;

    vx_csr_rmw #(
        .CORE_ID (0)
    ) dut (
`ifdef CSR_STALL_CNT_EN
        .perf_csr_stalls  (perf),
`endif
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_wid          (req_wid),
        .req_tmask        (req_tmask),
        .req_PC           (req_PC),
        .req_rd           (req_rd),
        .req_wb           (req_wb),
        .req_op           (req_op),
        .req_use_imm      (req_use_imm),
        .req_imm          (req_imm),
        .req_addr         (req_addr),
        .req_rs1_data     (req_rs1_data),
        .csr_read_enable  (csr_read_enable),
        .csr_read_addr    (csr_read_addr),
        .csr_read_wid     (csr_read_wid),
        .csr_read_data    (csr_read_data),
        .csr_write_enable (csr_write_enable),
        .csr_write_addr   (csr_write_addr),
        .csr_write_wid    (csr_write_wid),
        .csr_write_data   (csr_write_data),
        .fpu_pending      (fpu_pending),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_wid          (rsp_wid),
        .rsp_tmask        (rsp_tmask),
        .rsp_PC           (rsp_PC),
        .rsp_rd           (rsp_rd),
        .rsp_wb           (rsp_wb),
        .rsp_data         (rsp_data),
        .busy             (busy)
    );

    // behavioural CSR file; 0xC00 returns the free-running cycle count
    logic [31:0] mem [NUM_WARPS][4096];
    logic        pl_en = 1'b0;
    logic [1:0]  pl_wid;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;
    logic [31:0] cyc = 32'd0;

    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        if (pl_en)
            mem[pl_wid][pl_addr] <= pl_data;
        else if (csr_write_enable)
            mem[csr_write_wid][csr_write_addr] <= csr_write_data;
    end

    assign csr_read_data = !csr_read_enable ? 32'd0 :
                           (csr_read_addr == 12'hC00) ? cyc :
                           mem[csr_read_wid][csr_read_addr];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_cyc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] w, input logic [11:0] a,
                           input logic [31:0] d);
        pl_en = 1'b1; pl_wid = w; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic drive(input logic [1:0] w, input logic [1:0] op,
                         input logic ui, input logic [4:0] imm,
                         input logic [11:0] a, input logic [31:0] rs1,
                         input logic [4:0] rd);
        req_valid    = 1'b1;
        req_wid      = w;
        req_op       = op;
        req_use_imm  = ui;
        req_imm      = imm;
        req_addr     = a;
        req_rs1_data = rs1;
        req_rd       = rd;
        req_tmask    = 4'hF;
        req_wb       = 1'b1;
        req_PC       = {20'h80000, a};
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b1; fpu_pending = '0;
        drive(2'd0, CSR_RW, 1'b0, 5'd0, 12'h340, 32'h77, 5'd1);
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_we", 32'(csr_write_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        tick();
        reset = 1'b0; req_valid = 1'b0;

        // 1: CSRRW MTVEC
        preload(2'd0, 12'h305, 32'h0);
        drive(2'd0, CSR_RW, 1'b0, 5'd0, 12'h305, 32'h8000_0100, 5'd10);
        #1;
        check("t1_ready", 32'(req_ready), 32'd1);
        check("t1_re", 32'(csr_read_enable), 32'd1);
        check("t1_raddr", 32'(csr_read_addr), 32'h305);
        check("t1_we", 32'(csr_write_enable), 32'd1);
        check("t1_wd", csr_write_data, 32'h8000_0100);
        tick();
        req_valid = 1'b0;
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_data", rsp_data, 32'h0);
        check("t1_rsp_rd", 32'(rsp_rd), 32'd10);
        check("t1_rsp_pc", rsp_PC, 32'h8000_0305);
        tick();
        check("t1_rsp_drop", 32'(rsp_valid), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: CSRRS MIE x0, then CSRRSI 3, then re-read
        preload(2'd1, 12'h304, 32'h8);
        drive(2'd1, CSR_RS, 1'b0, 5'd0, 12'h304, 32'h0, 5'd2);
        #1;
        check("t2_rs0_we", 32'(csr_write_enable), 32'd0);
        tick();
        drive(2'd1, CSR_RS, 1'b1, 5'h3, 12'h304, 32'hFFFF_FFFF, 5'd3);
        #1;
        check("t2_rs0_data", rsp_data, 32'h8);
        check("t2_rsi_we", 32'(csr_write_enable), 32'd1);
        check("t2_rsi_wd", csr_write_data, 32'hB);
        tick();
        drive(2'd1, CSR_RS, 1'b0, 5'd0, 12'h304, 32'h0, 5'd4);
        #1;
        check("t2_rsi_data", rsp_data, 32'h8);
        tick();
        req_valid = 1'b0;
        check("t2_reread", rsp_data, 32'hB);
        check("t2_rsp_wid", 32'(rsp_wid), 32'd1);

        // 3: CSRRCI FCSR with FPU pending for 3 cycles
        preload(2'd2, 12'h003, 32'hE1);
        fpu_pending = 4'b0100;
        drive(2'd2, CSR_RC, 1'b1, 5'h01, 12'h003, 32'h0, 5'd5);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_ready", 32'(req_ready), 32'd0);
            check("t3_stall_we", 32'(csr_write_enable), 32'd0);
            tick();
        end
        fpu_pending = '0;
        #1;
        check("t3_ready", 32'(req_ready), 32'd1);
        check("t3_we", 32'(csr_write_enable), 32'd1);
        check("t3_wd", csr_write_data, 32'hE0);
        tick();
        req_valid = 1'b0;
        check("t3_rsp_data", rsp_data, 32'hE1);
`ifdef CSR_STALL_CNT_EN
        check("t3_perf", perf[31:0], 32'd3);
`endif
        tick();

        // 4: CSRRW CYCLE (read-only)
        drive(2'd0, CSR_RW, 1'b0, 5'd0, 12'hC00, 32'hFFFF_FFFF, 5'd6);
        #1;
        exp_cyc = cyc;
        check("t4_we", 32'(csr_write_enable), 32'd0);
        tick();
        req_valid = 1'b0;
        check("t4_rsp_data", rsp_data, exp_cyc);
        tick();

        // 5: backpressure with a second request waiting
        preload(2'd3, 12'h340, 32'hAA);
        rsp_ready = 1'b0;
        drive(2'd3, CSR_RW, 1'b0, 5'd0, 12'h340, 32'h11, 5'd7);
        #1;
        check("t5_a_we", 32'(csr_write_enable), 32'd1);
        tick();
        drive(2'd3, CSR_RS, 1'b0, 5'd0, 12'h340, 32'h100, 5'd8);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t5_bp_ready", 32'(req_ready), 32'd0);
            check("t5_bp_valid", 32'(rsp_valid), 32'd1);
            check("t5_bp_data", rsp_data, 32'hAA);
            check("t5_bp_rd", 32'(rsp_rd), 32'd7);
            check("t5_bp_we", 32'(csr_write_enable), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("t5_b_ready", 32'(req_ready), 32'd1);
        check("t5_b_we", 32'(csr_write_enable), 32'd1);
        check("t5_b_wd", csr_write_data, 32'h111);
        tick();
        req_valid = 1'b0;
        check("t5_b_valid", 32'(rsp_valid), 32'd1);
        check("t5_b_data", rsp_data, 32'h11);
        check("t5_b_rd", 32'(rsp_rd), 32'd8);
`ifdef CSR_STALL_CNT_EN
        check("t5_perf", perf[31:0], 32'd7);
`endif
        tick();
        check("t5_no_dup", 32'(rsp_valid), 32'd0);

        // 6: reset while a response is held
        rsp_ready = 1'b0;
        drive(2'd3, CSR_RW, 1'b0, 5'd0, 12'h340, 32'h55, 5'd9);
        tick();
        check("t6_valid", 32'(rsp_valid), 32'd1);
        check("t6_data", rsp_data, 32'h111);
        reset = 1'b1;
        drive(2'd3, CSR_RW, 1'b0, 5'd0, 12'h340, 32'h99, 5'd11);
        #1;
        check("t6_rst_we", 32'(csr_write_enable), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        tick();
        check("t6_rst_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_data", rsp_data, 32'h0);
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        drive(2'd3, CSR_RS, 1'b0, 5'd0, 12'h340, 32'h0, 5'd12);
        tick();
        req_valid = 1'b0;
        check("t6_after", rsp_data, 32'h55);
`ifdef CSR_STALL_CNT_EN
        check("t6_perf", perf[31:0], 32'd0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
